collisionbg_arbiter: RTL and testbench

Shares the single-port collision-background ROM (640x480 entries of 4-bit palette indices, 1-cycle read latency) between the VGA pixel fetch and up to NUM_REQ game-logic collision queries. VGA fetch has absolute priority while video is active. Queries are served round-robin during blanking and answered with the stored index and a solid/empty hit flag. The block sits between the VGA controller, the collision ROM and the sprite/physics logic; the existing palette path consumes `pix_index`.

---
 rtl/collisionbg_arbiter.sv | 170 +++++++++++++++++
 tb/tb_collisionbg_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collisionbg_arbiter.sv
// collisionbg_arbiter
// Shares the single-port collision-background ROM between the VGA pixel fetch
// and NUM_REQ game-logic collision queries. While video is active (blank=1) the
// VGA fetch owns the ROM. During blanking, queries are granted round-robin and
// answered with the stored palette index and a solid/empty hit flag.
//
// Ports:
//   vga_clk      sole clock, rising edge
//   reset        asynchronous, active-high
//   DrawX/DrawY  current VGA pixel coordinate
//   blank        1 = active video (VGA owns the ROM), 0 = blanking
//   rom_address  ROM address (combinational)
//   rom_q        ROM data, valid one cycle after its address
//   pix_index    registered VGA pixel index (two-cycle latency)
//   req          per-requester query request (level)
//   qx/qy        packed query coordinates, requester i uses [10i+9:10i]
//   ack          one-cycle, one-hot response strobe
//   resp_index   response index, held until the next ack
//   resp_hit     response solid flag, held until the next ack
//   busy         1 while a query is in flight
module collisionbg_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter logic [3:0]  OOB_INDEX = 4'hF
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    blank,
    output logic [18:0]             rom_address,
    input  logic [3:0]              rom_q,
    output logic [3:0]              pix_index,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*10-1:0]   qx,
    input  logic [NUM_REQ*10-1:0]   qy,
    output logic [NUM_REQ-1:0]      ack,
    output logic [3:0]              resp_index,
    output logic                    resp_hit,
    output logic                    busy
);

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt;
    logic [COORD_W-1:0] gx;
    logic [COORD_W-1:0] gy;
    logic               oob;
    logic               owner_d;

    logic [COORD_W-1:0] qx_arr [NUM_REQ];
    logic [COORD_W-1:0] qy_arr [NUM_REQ];

    logic               any_req_c;
    logic [PTR_W-1:0]   pick_c;

    // Row-major ROM address: y*H_ACTIVE + x
    function automatic logic [ADDR_W-1:0] xy_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
    endfunction

    // Unpack the per-requester coordinate buses
    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign qx_arr[i] = qx[COORD_W*i +: COORD_W];
        assign qy_arr[i] = qy[COORD_W*i +: COORD_W];
    end

    // Round-robin pick: first requester with req set, searching upward from ptr
    always_comb begin
        int unsigned idx;
        any_req_c = 1'b0;
        pick_c    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!any_req_c && req[PTR_W'(idx)]) begin
                any_req_c = 1'b1;
                pick_c    = PTR_W'(idx);
            end
        end
    end

    // The query only reaches the ROM in READ, and only if video is not active
    always_comb begin
        rom_address = xy_addr(DrawX, DrawY);
        if (state == READ && !blank) begin
            rom_address = oob ? '0 : xy_addr(gx, gy);
        end
    end

    // VGA pixel path: owner_d marks that last cycle's read belonged to VGA
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            owner_d   <= 1'b0;
            pix_index <= '0;
        end else begin
            owner_d   <= blank;
            pix_index <= owner_d ? rom_q : 4'd0;
        end
    end

    // Query FSM with registered responses
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            gx         <= '0;
            gy         <= '0;
            oob        <= 1'b0;
            ack        <= '0;
            resp_index <= '0;
            resp_hit   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (!blank && any_req_c) begin
                        gnt   <= pick_c;
                        gx    <= qx_arr[pick_c];
                        gy    <= qy_arr[pick_c];
                        oob   <= (32'(qx_arr[pick_c]) >= H_ACTIVE) ||
                                 (32'(qy_arr[pick_c]) >= V_ACTIVE);
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    // VGA preemption loses the read; retry later with ptr unchanged
                    if (blank) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    // rom_q now carries the query data; answer only if still wanted
                    if (req[gnt]) begin
                        resp_index <= oob ? OOB_INDEX : rom_q;
                        resp_hit   <= oob ? 1'b1 : (rom_q != 4'd0);
                        ack[gnt]   <= 1'b1;
                        ptr        <= (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + PTR_W'(1);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collisionbg_arbiter.sv
// Testbench for collisionbg_arbiter: behavioural ROM and reference model,
// per-cycle compare, directed literal checks, then randomized traffic.
module tb_collisionbg_arbiter;

    localparam int N = 4;

    logic            vga_clk = 1'b0;
    logic            reset   = 1'b1;
    logic [9:0]      DrawX   = '0;
    logic [9:0]      DrawY   = '0;
    logic            blank   = 1'b0;
    logic [18:0]     rom_address;
    logic [3:0]      rom_q   = '0;
    logic [3:0]      pix_index;
    logic [N-1:0]    req     = '0;
    logic [N*10-1:0] qx      = '0;
    logic [N*10-1:0] qy      = '0;
    logic [N-1:0]    ack;
    logic [3:0]      resp_index;
    logic            resp_hit;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // ROM content: (x^y)&0xF with one optional overridden entry
    logic        ovr_en   = 1'b0;
    int unsigned ovr_addr = 0;
    logic [3:0]  ovr_val  = '0;

    collisionbg_arbiter #(.NUM_REQ(N)) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .pix_index  (pix_index),
        .req        (req),
        .qx         (qx),
        .qy         (qy),
        .ack        (ack),
        .resp_index (resp_index),
        .resp_hit   (resp_hit),
        .busy       (busy)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_fn(input int unsigned a);
        if (ovr_en && a == ovr_addr) return ovr_val;
        return 4'((a % 640) ^ (a / 640));
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(32'(rom_address));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Query lifecycle: 0 = no query, 1 = address on the bus, 2 = data returning
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_g     = 0;
    int         m_qx    = 0;
    int         m_qy    = 0;
    bit         m_oob   = 0;
    logic [3:0] m_data  = '0;
    logic [N-1:0] m_ack = '0;
    logic [3:0] m_ri    = '0;
    logic       m_hit   = 1'b0;
    logic [3:0] m_pix   = '0;
    bit         m_vvalid = 0;
    logic [3:0] m_vval  = '0;
    bit         m_found = 0;
    int         m_idx   = 0;

    always @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_ack = '0; m_ri = '0; m_hit = 1'b0;
            m_pix = '0; m_vvalid = 0; m_vval = '0;
        end else begin
            // Pixel visible two cycles after its address, only if VGA owned the read
            m_pix    = m_vvalid ? m_vval : 4'd0;
            m_vvalid = blank;
            m_vval   = rom_fn(32'(DrawY) * 640 + 32'(DrawX));
            m_ack    = '0;
            if (m_phase == 0) begin
                if (!blank && req != '0) begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        m_idx = (m_ptr + k) % N;
                        if (!m_found && req[m_idx]) begin
                            m_found = 1;
                            m_g = m_idx;
                        end
                    end
                    m_qx    = int'(qx[10*m_g +: 10]);
                    m_qy    = int'(qy[10*m_g +: 10]);
                    m_oob   = (m_qx >= 640) || (m_qy >= 480);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (blank) m_phase = 0;
                else begin
                    m_data  = rom_fn(32'(m_qy * 640 + m_qx));
                    m_phase = 2;
                end
            end else begin
                if (req[m_g]) begin
                    m_ack[m_g] = 1'b1;
                    m_ri  = m_oob ? 4'hF : m_data;
                    m_hit = m_oob ? 1'b1 : (m_data != 4'd0);
                    m_ptr = (m_g + 1) % N;
                end
                m_phase = 0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge vga_clk) begin
        int exp_addr;
        if (!reset) begin
            if (m_phase == 1 && !blank) exp_addr = m_oob ? 0 : m_qy * 640 + m_qx;
            else                        exp_addr = int'(DrawY) * 640 + int'(DrawX);
            check("m_rom_address", 32'(rom_address), 32'(exp_addr));
            check("m_ack", 32'(ack), 32'(m_ack));
            check("m_resp_index", 32'(resp_index), 32'(m_ri));
            check("m_resp_hit", 32'(resp_hit), 32'(m_hit));
            check("m_pix_index", 32'(pix_index), 32'(m_pix));
            check("m_busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_q(input int i, input int x, input int y);
        qx[10*i +: 10] = 10'(x);
        qy[10*i +: 10] = 10'(y);
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Count cycles until an ack is seen; -1 if none within the budget
    task automatic wait_ack(output int cyc, output logic [N-1:0] a);
        cyc = -1;
        a   = '0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ack != '0) begin
                cyc = c;
                a   = ack;
                break;
            end
        end
    endtask

    int           cyc;
    logic [N-1:0] a;
    int           nacks;
    int           last [N];
    int           blank_left;

    initial begin
        // Reset state
        repeat (3) step();
        @(negedge vga_clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_resp_index", 32'(resp_index), 0);
        check("rst_resp_hit", 32'(resp_hit), 0);
        check("rst_pix_index", 32'(pix_index), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge vga_clk); #3;
        reset = 1'b0;

        // VGA sweep over one line at DrawY=10
        blank = 1'b1;
        DrawY = 10'd10;
        for (int x = 0; x < 642; x++) begin
            step();
            DrawX = 10'(x % 640);
            if (x >= 2) check("vga_pix", 32'(pix_index), 32'(((x - 2) ^ 10) & 15));
        end
        step();
        blank = 1'b0;
        DrawX = 10'd100;
        DrawY = 10'd200;
        step(); step();

        // All four requesters held: acks 0,1,2,3,0.. spaced 3 cycles
        for (int i = 0; i < N; i++) begin
            set_q(i, 20 * i + 1, 7);
            last[i] = 0;
        end
        req   = '1;
        nacks = 0;
        for (int c = 1; c <= 30 && nacks < 8; c++) begin
            step();
            if (ack != '0) begin
                check("rr_order", 32'(ack), 32'(1 << (nacks % N)));
                check("rr_spacing", 32'(c), 32'(3 * (nacks + 1)));
                for (int i = 0; i < N; i++)
                    if (ack[i]) begin
                        check("rr_max_wait", 32'(c - last[i] <= 12), 1);
                        last[i] = c;
                    end
                nacks++;
            end
        end
        check("rr_ack_count", 32'(nacks), 8);
        req = '0;
        step(); step(); step();

        // Single query, stored 7 at address 1925 (x=5, y=3)
        ovr_en = 1'b1; ovr_addr = 1925; ovr_val = 4'h7;
        set_q(1, 5, 3);
        req = 4'b0010;
        wait_ack(cyc, a);
        check("q_latency", 32'(cyc), 3);
        check("q_ack", 32'(a), 32'(4'b0010));
        check("q_resp_index", 32'(resp_index), 7);
        check("q_resp_hit", 32'(resp_hit), 1);
        req = '0;
        step(); step();
        ovr_val = 4'h0;
        req = 4'b0010;
        wait_ack(cyc, a);
        check("q0_latency", 32'(cyc), 3);
        check("q0_resp_index", 32'(resp_index), 0);
        check("q0_resp_hit", 32'(resp_hit), 0);
        req = '0;
        ovr_en = 1'b0;
        step(); step();

        // VGA preempts the query in READ, then it is retried
        set_q(2, 10, 20);
        req = 4'b0100;
        step();
        blank = 1'b1;
        @(negedge vga_clk);
        check("pre_rom_address", 32'(rom_address), 128100);
        check("pre_busy", 32'(busy), 1);
        nacks = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ack != '0) nacks++;
        end
        check("pre_no_ack", 32'(nacks), 0);
        blank = 1'b0;
        wait_ack(cyc, a);
        check("pre_retry_latency", 32'(cyc), 3);
        check("pre_retry_ack", 32'(a), 32'(4'b0100));
        check("pre_retry_index", 32'(resp_index), 14);
        check("pre_retry_hit", 32'(resp_hit), 1);
        req = '0;
        step(); step();

        // Off-screen queries: x beyond the line, then y beyond the frame
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_q(0, 700, 0);
            else        set_q(0, 0, 480);
            req = 4'b0001;
            @(posedge vga_clk);
            @(negedge vga_clk);
            check("oob_rom_address", 32'(rom_address), 0);
            wait_ack(cyc, a);
            check("oob_latency", 32'(cyc), 2);
            check("oob_ack", 32'(a), 32'(4'b0001));
            check("oob_resp_index", 32'(resp_index), 15);
            check("oob_resp_hit", 32'(resp_hit), 1);
            req = '0;
            step(); step();
        end

        // Reset asserted while the query is in WAIT
        set_q(3, 1, 2);
        req = 4'b1000;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_ack", 32'(ack), 0);
        check("rstw_resp_index", 32'(resp_index), 0);
        check("rstw_resp_hit", 32'(resp_hit), 0);
        check("rstw_pix_index", 32'(pix_index), 0);
        check("rstw_busy", 32'(busy), 0);
        @(posedge vga_clk); #3;
        reset = 1'b0;
        set_q(1, 3, 3);
        req = 4'b1010;
        wait_ack(cyc, a);
        check("rstw_first_latency", 32'(cyc), 3);
        check("rstw_first_grant", 32'(a), 32'(4'b0010));
        req = '0;
        step(); step(); step();

        // Randomized traffic against the model
        blank_left = 20;
        for (int c = 0; c < 4000; c++) begin
            step();
            DrawX = (DrawX == 10'd639) ? 10'd0 : DrawX + 10'd1;
            if (DrawX == 10'd0) DrawY = (DrawY == 10'd479) ? 10'd0 : DrawY + 10'd1;
            if (blank_left == 0) begin
                blank      = ~blank;
                blank_left = int'($urandom_range(2, 40));
            end else begin
                blank_left--;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else set_q(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639)),
                                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479)));
                    end else if ($urandom_range(0, 99) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_q(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639)),
                             ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479)));
                end
            end
        end

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
